spi_target: RTL and testbench
=============================

# spi_target

SPI target (peripheral-side) endpoint: the far end of the system's SPI master link (mode 0, MSB first, active-low chip select). It oversamples `spi_clk`/`spi_csn`/`spi_mosi` on its own clock, deserializes MOSI bytes into an RX FIFO and serializes bytes from a TX FIFO onto MISO. It sits between the SPI pins and a byte-stream consumer/producer such as a sensor model, a loopback bench or a second core's MMIO.

## Interface
Parameters:
- `LGDEPTH`, 2: log2 of each FIFO depth (4 entries by default).
- `FILL`, 8'hff: byte shifted out when no TX byte is available.

Ports:
- `clk`  in  1  sole clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `spi_clk`  in  1  serial clock from master; asynchronous to `clk`.
- `spi_csn`  in  1  chip select, active low; asynchronous.
- `spi_mosi`  in  1  serial data from master; asynchronous.
- `spi_miso`  out  1  serial data to master.
- `rx_data`  out  8  head of RX FIFO.
- `rx_valid`  out  1  RX FIFO non-empty.
- `rx_ready`  in  1  consumer pops when `rx_valid && rx_ready`.
- `tx_data`  in  8  byte to enqueue.
- `tx_valid`  in  1  producer pushes when `tx_valid && tx_ready`.
- `tx_ready`  out  1  TX FIFO not full.
- `overrun`  out  1  sticky: a received byte was dropped.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- Each of `spi_clk`, `spi_csn`, `spi_mosi` passes through a 2-flop synchronizer; a third register on `spi_clk`/`spi_csn` gives edge detection (rise, fall).
- State machine: IDLE (synced csn high) and ACTIVE (synced csn low).
- IDLE -> ACTIVE on csn fall: bit counter := 0; TX shift register := pop of TX FIFO if non-empty, else `FILL` (or echo, see Configuration). `spi_miso` = shift register bit 7.
- ACTIVE, sclk rise: RX shift := {RX shift[6:0], synced mosi}; counter += 1. When counter reaches 8: push completed byte into RX FIFO, counter := 0.
- ACTIVE, sclk fall: if counter != 0, TX shift <<= 1 (next bit onto MISO); if counter == 0 (byte boundary), reload TX shift exactly as at csn fall.
- ACTIVE -> IDLE on csn rise: partial RX bits discarded, counter := 0; a partially shifted TX byte is lost (not requeued). MISO held 1 in IDLE.
- RX push while RX FIFO full and no pop in the same cycle: byte dropped, `overrun` := 1. Push and pop in the same cycle when full: accepted, no overrun.
- TX push when full: refused (`tx_ready` = 0). TX pop and push in the same cycle: both take effect.
- `overrun_clr` together with a new overrun event: set wins.
- FIFO pointers are LGDEPTH+1 bits and wrap modulo 2^(LGDEPTH+1); full = MSBs differ, low bits equal.

## Timing
- Reset values: `spi_miso` = 1, `rx_valid` = 0, `rx_data` = 0, `tx_ready` = 1, `overrun` = 0; FIFOs empty, state IDLE, synchronizers at csn=1, sclk=0, mosi=0.
- Pin edge to internal detection: 3 `clk` cycles. `spi_miso` updates 1 cycle after detection (4 cycles after the pin edge).
- Master constraint: each `spi_clk` half-period and the csn-fall to first-sclk-rise gap must be at least 6 `clk` cycles, so MISO is stable before the master samples on sclk rise.
- RX: `rx_valid` rises the cycle after the 8th sclk rise is detected. Pop is visible on `rx_valid`/`rx_data` next cycle.
- TX: `tx_ready` is registered and falls the cycle after the push that fills the FIFO.
- Reset asserted mid-byte: immediate return to reset values; no partial byte is pushed.

## Configuration
- `SPI_TARGET_ECHO_EN` defined: a reload with an empty TX FIFO shifts out the most recently received RX byte (reset value `FILL`) instead of `FILL`.
- Undefined: an empty TX FIFO always yields `FILL`.

## Test plan
- Reset, then csn low and 8 sclk cycles with MOSI = 8'hA5 -> `rx_valid` = 1, `rx_data` = 8'hA5; MISO bits all 1 (`FILL`).
- Push 8'h3C, 8'hC3 into TX, then transfer 2 bytes -> master reads 8'h3C, 8'hC3; `tx_ready` stays 1.
- Hold `rx_ready` = 0 and send 5 bytes with LGDEPTH=2 -> first 4 retained in order, 5th dropped, `overrun` = 1; pulse `overrun_clr` -> `overrun` = 0.
- Raise csn after 5 bits of 8'hFF, then send a full 8'h12 -> only 8'h12 appears in RX FIFO.
- With `SPI_TARGET_ECHO_EN`, empty TX FIFO, send 8'h5A then 8'h00 -> second MISO byte is 8'h5A; without the macro it is 8'hff.
- Assert `resetn` low mid-byte -> all outputs return to reset values at once; the next full transfer of 8'h81 is received correctly.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 target endpoint: oversampled pins, byte deserializer into an RX FIFO,
// serializer from a TX FIFO. Define SPI_TARGET_ECHO_EN to echo the last RX byte on TX underflow.
module spi_target #(
    parameter int          LGDEPTH = 2,
    parameter logic [7:0]  FILL    = 8'hff
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       spi_clk,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       overrun,
    input  logic       overrun_clr
);
    localparam int DEPTH = 1 << LGDEPTH;
    localparam int PW    = LGDEPTH + 1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sclk_sync_q, sclk_sync_d, csn_sync_q, csn_sync_d;
    logic [1:0]       mosi_sync_q, mosi_sync_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic             miso_q, miso_d, overrun_q, overrun_d;
    logic [7:0]       rx_mem_q [DEPTH], rx_mem_d [DEPTH];
    logic [7:0]       tx_mem_q [DEPTH], tx_mem_d [DEPTH];
    logic [PW-1:0]    rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [PW-1:0]    tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic             sclk_rise_s, sclk_fall_s, csn_rise_s, csn_fall_s;
    logic             rx_push_s, rx_full_s, rx_empty_s, rx_pop_s, rx_wr_s;
    logic             tx_pop_s, tx_full_s, tx_empty_s, tx_push_s;
    logic [7:0]       rx_byte_s, reload_s, fill_s;

`ifdef SPI_TARGET_ECHO_EN
    logic [7:0]       last_rx_q, last_rx_d;
    assign fill_s    = last_rx_q;
    assign last_rx_d = rx_push_s ? rx_byte_s : last_rx_q;
`else
    assign fill_s    = FILL;
`endif

    assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign csn_rise_s  = csn_sync_q[1] & ~csn_sync_q[2];
    assign csn_fall_s  = ~csn_sync_q[1] & csn_sync_q[2];

    assign rx_empty_s = (rx_wptr_q == rx_rptr_q);
    assign rx_full_s  = (rx_wptr_q[LGDEPTH] != rx_rptr_q[LGDEPTH]) &&
                        (rx_wptr_q[LGDEPTH-1:0] == rx_rptr_q[LGDEPTH-1:0]);
    assign tx_empty_s = (tx_wptr_q == tx_rptr_q);
    assign tx_full_s  = (tx_wptr_q[LGDEPTH] != tx_rptr_q[LGDEPTH]) &&
                        (tx_wptr_q[LGDEPTH-1:0] == tx_rptr_q[LGDEPTH-1:0]);
    assign rx_byte_s  = {rx_shift_q[6:0], mosi_sync_q[1]};
    assign reload_s   = tx_empty_s ? fill_s : tx_mem_q[tx_rptr_q[LGDEPTH-1:0]];

    // Link state machine: framing, bit counting and shift registers
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_push_s   = 1'b0;
        tx_pop_s    = 1'b0;
        sclk_sync_d = {sclk_sync_q[1:0], spi_clk};
        csn_sync_d  = {csn_sync_q[1:0], spi_csn};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
        case (state_q)
            IDLE: begin
                if (csn_fall_s) begin
                    state_d    = ACTIVE;
                    cnt_d      = 3'd0;
                    tx_shift_d = reload_s;
                    tx_pop_s   = ~tx_empty_s;
                end else begin
                    cnt_d = 3'd0;
                end
            end
            ACTIVE: begin
                if (csn_rise_s) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (sclk_rise_s) begin
                    rx_shift_d = rx_byte_s;
                    if (cnt_q == 3'd7) begin
                        rx_push_s = 1'b1;
                        cnt_d     = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (sclk_fall_s) begin
                    // Byte boundary on the falling edge: next byte goes onto MISO
                    if (cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else begin
                        tx_shift_d = reload_s;
                        tx_pop_s   = ~tx_empty_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // FIFO bookkeeping, overrun flag and MISO output register
    always_comb begin
        rx_mem_d  = rx_mem_q;
        tx_mem_d  = tx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        rx_pop_s  = ~rx_empty_s & rx_ready;
        rx_wr_s   = rx_push_s & (~rx_full_s | rx_pop_s);
        tx_push_s = tx_valid & ~tx_full_s;
        if (rx_wr_s) begin
            rx_mem_d[rx_wptr_q[LGDEPTH-1:0]] = rx_byte_s;
            rx_wptr_d = rx_wptr_q + PW'(1);
        end else begin
            rx_wptr_d = rx_wptr_q;
        end
        if (rx_pop_s) begin
            rx_rptr_d = rx_rptr_q + PW'(1);
        end else begin
            rx_rptr_d = rx_rptr_q;
        end
        if (tx_push_s) begin
            tx_mem_d[tx_wptr_q[LGDEPTH-1:0]] = tx_data;
            tx_wptr_d = tx_wptr_q + PW'(1);
        end else begin
            tx_wptr_d = tx_wptr_q;
        end
        if (tx_pop_s) begin
            tx_rptr_d = tx_rptr_q + PW'(1);
        end else begin
            tx_rptr_d = tx_rptr_q;
        end
        if (rx_push_s && rx_full_s && !rx_pop_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        miso_d = (state_q == ACTIVE) ? tx_shift_q[7] : 1'b1;
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            sclk_sync_q <= 3'b000;
            csn_sync_q  <= 3'b111;
            mosi_sync_q <= 2'b00;
            cnt_q       <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'hff;
            miso_q      <= 1'b1;
            overrun_q   <= 1'b0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rx_mem_q[i] <= 8'h00;
                tx_mem_q[i] <= 8'h00;
            end
`ifdef SPI_TARGET_ECHO_EN
            last_rx_q   <= FILL;
`endif
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            csn_sync_q  <= csn_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            overrun_q   <= overrun_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            rx_mem_q    <= rx_mem_d;
            tx_mem_q    <= tx_mem_d;
`ifdef SPI_TARGET_ECHO_EN
            last_rx_q   <= last_rx_d;
`endif
        end
    end

    assign spi_miso = miso_q;
    assign rx_valid = ~rx_empty_s;
    assign rx_data  = rx_mem_q[rx_rptr_q[LGDEPTH-1:0]];
    assign tx_ready = ~tx_full_s;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: table-driven single-byte frames plus hand-written
// multi-cycle sequences; RX bytes and MISO bytes are checked through scoreboard queues.
module tb_spi_target;
    localparam int HALF = 8;
`ifdef SPI_TARGET_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       spi_clk = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       overrun, overrun_clr;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];

    typedef struct {
        logic [7:0] mosi;
        logic       push;
        logic [7:0] txb;
        logic [7:0] exp_miso;
        logic [7:0] exp_miso_echo;
    } vec_t;
    vec_t tab[6];

    spi_target #(.LGDEPTH(2), .FILL(8'hff)) dut (
        .clk(clk), .resetn(resetn),
        .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sbit(input logic b, output logic m);
        spi_mosi = b;
        wait_n(HALF);
        spi_clk = 1'b1;
        m = spi_miso;
        wait_n(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] mo, input logic chk_miso, input string tag);
        logic [7:0] mi;
        logic       m;
        for (int i = 7; i >= 0; i--) begin
            sbit(mo[i], m);
            mi[i] = m;
        end
        if (chk_miso && miso_q.size() > 0) chk({tag, "_miso"}, {24'd0, mi}, {24'd0, miso_q.pop_front()});
    endtask

    task automatic csn_lo();
        spi_csn = 1'b0;
        wait_n(HALF);
    endtask

    task automatic csn_hi();
        wait_n(HALF);
        spi_csn = 1'b1;
        wait_n(HALF);
    endtask

    task automatic tx_push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        wait_n(1);
        tx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 64;
        while (rx_q.size() > 0 && budget > 0) begin
            if (rx_valid) begin
                chk({tag, "_rx"}, {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
                rx_ready = 1'b1;
                wait_n(1);
                rx_ready = 1'b0;
            end else begin
                wait_n(1);
            end
            budget--;
        end
        chk({tag, "_rx_missing"}, rx_q.size(), 32'd0);
        rx_q.delete();
        chk({tag, "_rx_extra"}, {31'd0, rx_valid}, 32'd0);
    endtask

    initial begin
        logic m;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; overrun_clr = 1'b0;
        wait_n(3);
        chk("rst_miso", {31'd0, spi_miso}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        resetn = 1'b1;
        wait_n(4);

        // mosi, push, tx byte, expected MISO (default build), expected MISO (echo build)
        tab[0] = '{8'hA5, 1'b0, 8'h00, 8'hff, 8'hff};
        tab[1] = '{8'h3C, 1'b1, 8'h3C, 8'h3C, 8'h3C};
        tab[2] = '{8'h00, 1'b1, 8'hC3, 8'hC3, 8'hC3};
        tab[3] = '{8'hFF, 1'b0, 8'h00, 8'hff, 8'h00};
        tab[4] = '{8'h81, 1'b1, 8'h55, 8'h55, 8'h55};
        tab[5] = '{8'h7E, 1'b0, 8'h00, 8'hff, 8'h81};
        for (int i = 0; i < 6; i++) begin
            if (tab[i].push) tx_push(tab[i].txb);
            rx_q.push_back(tab[i].mosi);
            miso_q.push_back(ECHO ? tab[i].exp_miso_echo : tab[i].exp_miso);
            csn_lo();
            xfer(tab[i].mosi, 1'b1, $sformatf("vec%0d", i));
            csn_hi();
            drain($sformatf("vec%0d", i));
        end

        // two bytes in one frame from a preloaded TX FIFO
        tx_push(8'h3C);
        chk("two_tx_ready0", {31'd0, tx_ready}, 32'd1);
        tx_push(8'hC3);
        chk("two_tx_ready1", {31'd0, tx_ready}, 32'd1);
        miso_q.push_back(8'h3C); miso_q.push_back(8'hC3);
        rx_q.push_back(8'h11); rx_q.push_back(8'h22);
        csn_lo();
        xfer(8'h11, 1'b1, "two_b0");
        xfer(8'h22, 1'b1, "two_b1");
        csn_hi();
        chk("two_tx_ready2", {31'd0, tx_ready}, 32'd1);
        drain("two");

        // RX overrun with consumer stalled
        for (int b = 1; b <= 5; b++) begin
            csn_lo();
            xfer(8'(b), 1'b0, "ovr");
            csn_hi();
            if (b <= 4) rx_q.push_back(8'(b));
        end
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        drain("ovr");
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        wait_n(1);
        overrun_clr = 1'b0;
        chk("ovr_clr", {31'd0, overrun}, 32'd0);

        // partial byte aborted by csn rise is discarded
        csn_lo();
        for (int i = 0; i < 5; i++) sbit(1'b1, m);
        csn_hi();
        rx_q.push_back(8'h12);
        csn_lo();
        xfer(8'h12, 1'b0, "part");
        csn_hi();
        drain("part");

        // TX underflow: fill byte or echo of the previous RX byte
        miso_q.push_back(ECHO ? 8'h12 : 8'hff);
        miso_q.push_back(ECHO ? 8'h5A : 8'hff);
        rx_q.push_back(8'h5A); rx_q.push_back(8'h00);
        csn_lo();
        xfer(8'h5A, 1'b1, "echo_b0");
        xfer(8'h00, 1'b1, "echo_b1");
        csn_hi();
        drain("echo");

        // TX FIFO full: refused push, then a 5-byte frame that also overruns RX
        tx_push(8'hAA); tx_push(8'hBB); tx_push(8'hCC);
        chk("full_ready3", {31'd0, tx_ready}, 32'd1);
        tx_push(8'hDD);
        chk("full_ready4", {31'd0, tx_ready}, 32'd0);
        tx_push(8'hEE);
        chk("full_refused", {31'd0, tx_ready}, 32'd0);
        miso_q.push_back(8'hAA); miso_q.push_back(8'hBB);
        miso_q.push_back(8'hCC); miso_q.push_back(8'hDD);
        miso_q.push_back(ECHO ? 8'h04 : 8'hff);
        csn_lo();
        for (int b = 1; b <= 5; b++) begin
            xfer(8'(b), 1'b1, $sformatf("full_b%0d", b));
            if (b <= 4) rx_q.push_back(8'(b));
        end
        csn_hi();
        chk("full_ready_after", {31'd0, tx_ready}, 32'd1);
        chk("full_overrun", {31'd0, overrun}, 32'd1);
        drain("full");

        // reset asserted mid-byte with RX data pending and overrun set
        csn_lo();
        xfer(8'h9A, 1'b0, "mid");
        csn_hi();
        csn_lo();
        for (int i = 0; i < 3; i++) sbit(1'b1, m);
        resetn = 1'b0;
        #1;
        chk("mid_rst_miso", {31'd0, spi_miso}, 32'd1);
        chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        wait_n(4);
        resetn = 1'b1;
        wait_n(4);
        miso_q.push_back(8'hff);
        rx_q.push_back(8'h81);
        csn_lo();
        xfer(8'h81, 1'b1, "post_rst");
        csn_hi();
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
